// File: rtl/proj_pkg.sv
// Shared types and default widths for the sequence streamer.
// Ordering option PROJ_STREAM_MSB_FIRST_EN is consumed by proj_sym_shifter.
package proj_pkg;

  localparam int PROJ_DATA_BITS = 2;
  localparam int PROJ_WORD_SYMS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } stream_state_t;

endpackage

// File: rtl/proj_sym_shifter.sv
// Load/advance symbol shift register exposing the head symbol.
// PROJ_STREAM_MSB_FIRST_EN selects MSB-first ordering; default is LSB-first.
module proj_sym_shifter
  import proj_pkg::*;
#(
  parameter int DATA_BITS = PROJ_DATA_BITS,
  parameter int WORD_SYMS = PROJ_WORD_SYMS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_i,
  input  logic                           advance_i,
  input  logic [WORD_SYMS*DATA_BITS-1:0] word_i,
  output logic [DATA_BITS-1:0]           head_o
);

  localparam int WORD_W = WORD_SYMS * DATA_BITS;

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;

  // A refill loads the next word on the same edge the last symbol leaves,
  // so load takes priority over advance.
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = word_i;
    end else if (advance_i) begin
`ifdef PROJ_STREAM_MSB_FIRST_EN
      shift_d = shift_q << DATA_BITS;
`else
      shift_d = shift_q >> DATA_BITS;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

`ifdef PROJ_STREAM_MSB_FIRST_EN
  assign head_o = shift_q[WORD_W-1 -: DATA_BITS];
`else
  assign head_o = shift_q[DATA_BITS-1:0];
`endif

endmodule

// File: rtl/proj_seq_streamer.sv
// Serializes packed nucleotide words into a one-symbol-per-cycle k-mer stream.
// Symbol order is set by PROJ_STREAM_MSB_FIRST_EN inside proj_sym_shifter.
//
// state | meaning
// IDLE  | waiting for seq_start
// CLEAR | one-cycle start_over pulse to the k-mer buffer
// LOAD  | waiting for a packed word (in_ready high)
// SHIFT | presenting symbols; zero-bubble refill on the last symbol of a word
// DONE  | one-cycle done pulse
module proj_seq_streamer
  import proj_pkg::*;
#(
  parameter int DATA_BITS = PROJ_DATA_BITS,
  parameter int WORD_SYMS = PROJ_WORD_SYMS,
  parameter int LEN_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           seq_start,
  input  logic [LEN_W-1:0]               seq_len,
  input  logic [WORD_SYMS*DATA_BITS-1:0] in_word,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_BITS-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_start_over,
  output logic                           busy,
  output logic                           done
);

  localparam int                WC_W    = $clog2(WORD_SYMS + 1);
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_WS  = LEN_W'(WORD_SYMS);
  localparam logic [WC_W-1:0]   WC_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0]   WC_FULL = WC_W'(WORD_SYMS);

  stream_state_t     state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              sh_load, sh_adv;
  logic [DATA_BITS-1:0] head;

  function automatic logic [WC_W-1:0] word_fill(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_WS) return WC_FULL;
    return rem[WC_W-1:0];
  endfunction

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    wc_d           = wc_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_start_over = 1'b0;
    done           = 1'b0;
    sh_load        = 1'b0;
    sh_adv         = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_start) begin
          if (seq_len != '0) begin
            rem_d   = seq_len;
            state_d = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLEAR: begin
        out_start_over = 1'b1;
        state_d        = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_load = 1'b1;
          wc_d    = word_fill(rem_q);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        in_ready  = out_ready && (wc_q == WC_ONE) && (rem_q > LEN_ONE);
        if (out_ready) begin
          sh_adv = 1'b1;
          if (rem_q != '0) rem_d = rem_q - LEN_ONE;
          if (wc_q != '0)  wc_d  = wc_q - WC_ONE;
          if (rem_q <= LEN_ONE) begin
            state_d = DONE;
          end else if (wc_q == WC_ONE) begin
            if (in_valid) begin
              sh_load = 1'b1;
              wc_d    = word_fill(rem_q - LEN_ONE);
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wc_q    <= wc_d;
    end
  end

  proj_sym_shifter #(
    .DATA_BITS(DATA_BITS),
    .WORD_SYMS(WORD_SYMS)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (sh_load),
    .advance_i(sh_adv),
    .word_i   (in_word),
    .head_o   (head)
  );

  assign out_data = out_valid ? head : '0;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_proj_seq_streamer.sv
// Randomized bench for proj_seq_streamer against a symbol-index reference model.
// Honors PROJ_STREAM_MSB_FIRST_EN for the expected symbol order.
module tb_proj_seq_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seq_start;
  logic [15:0] seq_len;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_start_over;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  proj_seq_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seq_start     (seq_start),
    .seq_len       (seq_len),
    .in_word       (in_word),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_start_over(out_start_over),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Symbol i of the sequence lives in word i/16 at slot i%16.
  function automatic logic [1:0] exp_sym(input int i);
    logic [31:0] w;
    int s;
    w = wq[i / 16];
    s = i % 16;
`ifdef PROJ_STREAM_MSB_FIRST_EN
    s = 15 - s;
`endif
    return w[2*s +: 2];
  endfunction

  // rpct < 0 selects the fixed out_ready pattern 1,0,0,1,0,0,...
  task automatic run_seq(input int len, input int vpct, input int rpct,
                         input int rst_at, input bit tmg);
    int nwords, got, widx, n_so, n_done, n_hs, n_irdy, n_val;
    int done_cyc, last_cons, first_v, so_cyc, errs, c;
    bit hold_v, fin;
    logic [1:0] hold_d;
    nwords = (len + 15) / 16;
    got = 0; widx = 0; n_so = 0; n_done = 0; n_hs = 0; n_irdy = 0; n_val = 0;
    done_cyc = -1; last_cons = -1; first_v = -1; so_cyc = -1; errs = 0; c = 0;
    hold_v = 1'b0; fin = 1'b0; hold_d = 2'b0;
    @(negedge clk);
    seq_start = 1'b1; seq_len = 16'(len);
    in_valid = 1'b0; out_ready = 1'b0; in_word = 32'h0;
    #1;
    chk("idle_before_start", {31'b0, busy}, 32'd0);
    while (!fin && c < 4*len + 100) begin
      @(negedge clk);
      c++;
      seq_start = ($urandom_range(9) == 0);
      seq_len   = 16'($urandom_range(40));
      in_valid  = ($urandom_range(99) < vpct);
      in_word   = (widx < nwords) ? wq[widx] : $urandom;
      out_ready = (rpct < 0) ? ((c % 3) == 0) : ($urandom_range(99) < rpct);
      #1;
      if (rst_at > 0 && out_valid && got == rst_at - 1) begin
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", {26'b0, in_ready, out_data, out_valid, out_start_over, busy, done}, 32'd0);
        repeat (2) begin
          @(negedge clk); #1;
          if (out_valid || done || busy) errs++;
        end
        rst_n = 1'b1;
        seq_start = 1'b0;
        repeat (4) begin
          @(negedge clk); #1;
          if (out_valid || done || busy || out_start_over) errs++;
        end
        chk("rst_no_activity", errs, 32'd0);
        in_valid = 1'b0; out_ready = 1'b0;
        return;
      end
      if (!out_valid && out_data != 2'b0) errs++;
      if (busy !== 1'b1) errs++;
      if (out_start_over) begin
        n_so++; so_cyc = c;
        if (n_val != 0) errs++;
      end
      if (in_ready) n_irdy++;
      if (out_valid) begin
        n_val++;
        if (first_v < 0) first_v = c;
        if (got >= len || got >= n_hs * 16) errs++;
        else chk("symbol", {30'b0, out_data}, {30'b0, exp_sym(got)});
        if (hold_v && out_data !== hold_d) errs++;
        if (out_ready) begin
          got++; last_cons = c; hold_v = 1'b0;
        end else begin
          hold_v = 1'b1; hold_d = out_data;
        end
      end
      if (in_ready && in_valid) begin
        n_hs++; widx++;
      end
      if (done) begin
        n_done++; done_cyc = c; fin = 1'b1;
        if (got != len) errs++;
      end
    end
    seq_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("finished", {31'b0, fin}, 32'd1);
    chk("symbol_count", got, len);
    chk("start_over_count", n_so, (len > 0) ? 1 : 0);
    chk("words_accepted", n_hs, nwords);
    chk("done_count", n_done, 32'd1);
    chk("done_latency", done_cyc, (len > 0) ? last_cons + 1 : 1);
    chk("protocol_errs", errs, 32'd0);
    if (len == 0) chk("zero_len_no_ready", n_irdy, 32'd0);
    if (tmg && len > 0) begin
      chk("start_over_cycle", so_cyc, 32'd1);
      chk("first_valid_cycle", first_v, 32'd3);
      chk("valid_cycles", n_val, len);
      chk("in_ready_cycles", n_irdy, nwords);
    end
  endtask

  task automatic fill_words(input int n, input bit rnd, input logic [31:0] w);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(rnd ? $urandom : w);
  endtask

  initial begin
    int len;
    rst_n = 1'b0; seq_start = 1'b0; seq_len = 16'h0;
    in_word = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {26'b0, in_ready, out_data, out_valid, out_start_over, busy, done}, 32'd0);
    rst_n = 1'b1;

    fill_words(1, 1'b0, 32'hE4E4E4E4);
    run_seq(16, 100, 100, 0, 1'b1);

    fill_words(2, 1'b1, 32'h0);
    run_seq(32, 100, 100, 0, 1'b1);

    fill_words(1, 1'b0, 32'hFFFFFF1B);
    run_seq(5, 100, 100, 0, 1'b1);

    fill_words(1, 1'b0, 32'hE4000000);
    run_seq(4, 100, 100, 0, 1'b1);

    fill_words(0, 1'b0, 32'h0);
    run_seq(0, 100, 100, 0, 1'b0);

    fill_words(1, 1'b1, 32'h0);
    run_seq(8, 100, -1, 0, 1'b0);

    fill_words(2, 1'b1, 32'h0);
    run_seq(20, 30, 100, 0, 1'b0);

    fill_words(2, 1'b1, 32'h0);
    run_seq(20, 100, 100, 7, 1'b0);

    for (int k = 0; k < 12; k++) begin
      len = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 50);
      fill_words((len + 15) / 16, 1'b1, 32'h0);
      run_seq(len, $urandom_range(50, 100), $urandom_range(40, 100), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/proj_seq_streamer.md
# proj_seq_streamer

Serializes packed nucleotide words into the one-symbol-per-cycle stream consumed by the k-mer buffer (`in_data` / `start_over` side). Accepts a sequence length, pulls packed words through a valid/ready handshake, and emits `DATA_BITS`-wide symbols. It pulses `start_over` before each new sequence so the downstream k-mer window restarts cleanly. It sits between the sequence fetch/memory interface and the k-mer buffer in the MinHash front end.

## Interface
- `DATA_BITS`, 2: bits per nucleotide symbol.
- `WORD_SYMS`, 16: symbols packed per input word; word width is `WORD_SYMS*DATA_BITS`.
- `LEN_W`, 16: width of the sequence-length field, in symbols.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `seq_start`  in  1: one-cycle request to begin a sequence; sampled only in IDLE.
- `seq_len`  in  `LEN_W`: sequence length in symbols; sampled with `seq_start`.
- `in_word`  in  `WORD_SYMS*DATA_BITS`: packed symbol word.
- `in_valid`  in  1: `in_word` is valid.
- `in_ready`  out  1: streamer accepts `in_word` this cycle.
- `out_data`  out  `DATA_BITS`: current symbol; drives the k-mer buffer `in_data`.
- `out_valid`  out  1: `out_data` is a real symbol.
- `out_ready`  in  1: downstream consumes the symbol this cycle.
- `out_start_over`  out  1: one-cycle pulse; drives the k-mer buffer `start_over`.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse after the last symbol is consumed.

## Operation
- FSM states are IDLE, CLEAR, LOAD, SHIFT and DONE.
- IDLE:
  - `seq_start` with `seq_len` > 0: latch `remaining = seq_len`, go to CLEAR.
  - `seq_start` with `seq_len` == 0: go directly to DONE. No `out_start_over` pulse and no word fetch.
- CLEAR: `out_start_over` = 1 for exactly one cycle, then go to LOAD.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid`: capture the word into the shift register, set `word_cnt = min(WORD_SYMS, remaining)`, go to SHIFT.
  - Without `in_valid`: stay in LOAD. `out_valid` stays 0.
- SHIFT:
  - `out_valid` = 1.
  - `out_data` = current symbol at the shift-register head.
  - On `out_ready`: advance the shift register by one symbol, decrement `remaining` and `word_cnt`.
  - If `remaining` becomes 0: go to DONE.
  - Else if `word_cnt` becomes 0: refill.
- Zero-bubble refill:
  - During SHIFT, `in_ready` = `out_ready` && (`word_cnt` == 1) && (`remaining` > 1). This is combinational from `out_ready`.
  - If `in_valid` is also high, the new word loads in the same edge and SHIFT continues.
  - Otherwise, go to LOAD.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- Final partial word: symbols beyond `remaining` are discarded and never presented.
- `seq_start` outside IDLE is ignored.
- `out_data` is 0 whenever `out_valid` = 0.
- Arithmetic:
  - `remaining` is an unsigned `LEN_W`-bit counter.
  - `word_cnt` is $clog2(WORD_SYMS+1) bits.
  - Neither counter wraps: decrements occur only when the counter is > 0.

## Timing
- Reset value of all outputs is 0. State resets to IDLE and the counters and shift register reset to 0.
- Reset asserted mid-sequence: the sequence is abandoned. No `done` pulse is produced and no further symbols are emitted.
- Latency with `in_valid` already high:
  - `seq_start` sampled at edge 0.
  - `out_start_over` is high in cycle 1.
  - `in_ready` is high in cycle 2.
  - The first `out_valid` is in cycle 3.
- Sustained throughput is one symbol per cycle across word boundaries when `in_valid` is high at each refill.
- `done` is asserted in the cycle after the edge that consumes the last symbol.
- The earliest next `seq_start` is accepted the cycle after `done`.

## Configuration
- `PROJ_STREAM_MSB_FIRST_EN` undefined: symbol 0 is `in_word[DATA_BITS-1:0]` (LSB first); the shift register shifts right.
- `PROJ_STREAM_MSB_FIRST_EN` defined: symbol 0 is `in_word[WORD_SYMS*DATA_BITS-1 -: DATA_BITS]`; the shift register shifts left.
- No port or timing change in either case.

## Structure
- `proj_pkg` holds:
  - the `stream_state_t` enum (IDLE, CLEAR, LOAD, SHIFT, DONE);
  - the default constants `PROJ_DATA_BITS` = 2 and `PROJ_WORD_SYMS` = 16.
- Sub-module `proj_sym_shifter`:
  - a load/advance shift register exposing the head symbol;
  - it owns the `PROJ_STREAM_MSB_FIRST_EN` ordering.
- The top level holds the FSM, `remaining` / `word_cnt` and the handshake logic.

## Test plan
- Basic stream: `seq_len` = 16, `in_word` = 32'hE4E4E4E4, `in_valid` and `out_ready` held high.
  - Expect one `out_start_over` pulse, then symbols 0,1,2,3 repeated 4 times.
  - Expect `done` one cycle after the 16th symbol; `in_ready` high only once.
- Zero-bubble refill: `seq_len` = 32, two words, `in_valid` and `out_ready` held high.
  - Expect 32 consecutive `out_valid` cycles with no gap at symbol 16.
  - Expect the second word accepted on the cycle of symbol 15.
- Partial word and zero length:
  - `seq_len` = 5, word 32'hFFFFFF1B: expect exactly symbols 3,2,1,0,3, then `done`; the rest of the word is discarded.
  - `seq_len` = 0: expect `done` on the next cycle with no `out_start_over` and no `in_ready`.
- Backpressure:
  - Toggle `out_ready` 1,0,0,1,… during `seq_len` = 8: `out_data` holds its value while `out_ready` = 0 and no symbol is dropped or duplicated.
  - Hold `in_valid` = 0 for 3 cycles in LOAD: `out_valid` = 0 throughout.
- Reset and ignore:
  - Assert `rst_n` = 0 at the 7th symbol: all outputs are 0 immediately and there is no `done`.
  - `seq_start` pulsed during SHIFT is ignored; the symbol count is unchanged.
- MSB-first build with `PROJ_STREAM_MSB_FIRST_EN`: `seq_len` = 4, word 32'hE4000000 gives symbols 3,2,1,0.
